// File: rtl/button_event_arbiter_if.sv
// Event channel between the button arbiter (master) and its single consumer (slave).
// BUTTON_LONG_PRESS_EN adds the evt_long qualifier.
interface button_event_arbiter_if #(
    parameter int unsigned IDW = 2
) ();
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_ready;
    logic           evt_overrun;
`ifdef BUTTON_LONG_PRESS_EN
    logic           evt_long;

    modport master (output evt_valid, evt_id, evt_overrun, evt_long, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_overrun, evt_long, output evt_ready);
`else
    modport master (output evt_valid, evt_id, evt_overrun, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_overrun, output evt_ready);
`endif
endinterface

// File: rtl/button_event_arbiter.sv
// Debounces N push-buttons on a shared tick and serialises presses onto one valid/ready channel
// via a round-robin arbiter. Define BUTTON_LONG_PRESS_EN to add long-press events.
module button_event_arbiter #(
    parameter int unsigned N_BUTTONS    = 4,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 4,
`ifdef BUTTON_LONG_PRESS_EN
    parameter int unsigned LONG_TICKS   = 250,
`endif
    parameter int unsigned IDW          = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BUTTONS-1:0]   btn_in_i,
    output logic [N_BUTTONS-1:0]   btn_level_o,
    button_event_arbiter_if.master evt
);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned StabW = $clog2(STABLE_TICKS + 1);

    typedef enum logic {StIdle, StOffer} state_e;

    logic [N_BUTTONS-1:0] sync1_q, sync_q, level_q, level_d, level_prev_q, rise;
    logic [N_BUTTONS-1:0] pending_q, pending_d, req, grant_oh, clr_short;
    logic [StabW-1:0]     stab_q [N_BUTTONS];
    logic [StabW-1:0]     stab_d [N_BUTTONS];
    logic [TickW-1:0]     tick_cnt_q;
    logic                 tick, grant_vld, load, hs, overrun_q, overrun_d;
    logic [IDW-1:0]       grant_idx, id_q, rr_ptr_q;
    state_e               state_q, state_d;

    assign tick = (tick_cnt_q == TickW'(TICK_DIV - 1));
    assign rise = level_q & ~level_prev_q;

    // Accept the new level the cycle after the stability count is reached.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BUTTONS; i++) begin
            stab_d[i] = stab_q[i];
            if (stab_q[i] == StabW'(STABLE_TICKS)) begin
                level_d[i] = sync_q[i];
                stab_d[i]  = '0;
            end else if (tick) begin
                stab_d[i] = (sync_q[i] != level_q[i]) ? stab_q[i] + StabW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync_q       <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            tick_cnt_q   <= '0;
            for (int i = 0; i < N_BUTTONS; i++) stab_q[i] <= '0;
        end else begin
            sync1_q      <= btn_in_i;
            sync_q       <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + TickW'(1);
            for (int i = 0; i < N_BUTTONS; i++) stab_q[i] <= stab_d[i];
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);

    logic [HoldW-1:0]     hold_q [N_BUTTONS];
    logic [HoldW-1:0]     hold_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] long_pend_q, long_pend_d;
    logic                 use_long, long_q;

    assign use_long = |long_pend_q;
    assign req      = use_long ? long_pend_q : pending_q;

    // Hold counter saturates at LONG_TICKS so each press fires at most once.
    always_comb begin
        long_pend_d = long_pend_q & ~((load && use_long) ? grant_oh : '0);
        for (int i = 0; i < N_BUTTONS; i++) begin
            hold_d[i] = hold_q[i];
            if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (tick && hold_q[i] != HoldW'(LONG_TICKS)) begin
                hold_d[i] = hold_q[i] + HoldW'(1);
                if (hold_d[i] == HoldW'(LONG_TICKS)) long_pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_pend_q <= '0;
            long_q      <= 1'b0;
            for (int i = 0; i < N_BUTTONS; i++) hold_q[i] <= '0;
        end else begin
            long_pend_q <= long_pend_d;
            if (load) long_q <= use_long;
            for (int i = 0; i < N_BUTTONS; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign clr_short = (load && !use_long) ? grant_oh : '0;
`else
    assign req       = pending_q;
    assign clr_short = load ? grant_oh : '0;
`endif

    // Round-robin scan upward from rr_ptr with wrap.
    always_comb begin
        int unsigned idx;
        logic [N_BUTTONS-1:0] sel;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < N_BUTTONS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_BUTTONS) idx = idx - N_BUTTONS;
            sel = N_BUTTONS'(1) << idx;
            if (!grant_vld && |(req & sel)) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
                grant_oh  = sel;
            end
        end
    end

    assign load      = (state_q == StIdle) && grant_vld;
    assign hs        = (state_q == StOffer) && evt.evt_ready;
    // A new press always sets pending, even when that bit is cleared by a grant this cycle.
    assign pending_d = (pending_q & ~clr_short) | rise;
    assign overrun_d = |(rise & pending_q & ~clr_short);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_vld) state_d = StOffer;
            StOffer: if (evt.evt_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
            id_q      <= '0;
            rr_ptr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (load) id_q <= grant_idx;
            if (hs)   rr_ptr_q <= (id_q == IDW'(N_BUTTONS - 1)) ? '0 : id_q + IDW'(1);
        end
    end

    always_comb begin
        btn_level_o     = level_q;
        evt.evt_valid   = (state_q == StOffer);
        evt.evt_id      = id_q;
        evt.evt_overrun = overrun_q;
`ifdef BUTTON_LONG_PRESS_EN
        evt.evt_long    = long_q;
`endif
    end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with TICK_DIV=4, STABLE_TICKS=3, N_BUTTONS=4.
// The long-press scenario runs only when BUTTON_LONG_PRESS_EN is defined.
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] level;

    button_event_arbiter_if #(.IDW(2)) evt_if ();

    button_event_arbiter #(
        .N_BUTTONS   (4),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
`ifdef BUTTON_LONG_PRESS_EN
        .LONG_TICKS  (10),
`endif
        .IDW         (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in_i   (btn),
        .btn_level_o(level),
        .evt        (evt_if.master)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Monitor: handshakes, valid-high cycles, overrun-high cycles.
    int unsigned cyc = 0, ev_n = 0, vcnt = 0, ocnt = 0, t4_bad = 0;
    int unsigned ev_id   [64];
    int unsigned ev_cyc  [64];
    int unsigned ev_long [64];
    logic        t4_watch = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (evt_if.evt_valid) vcnt <= vcnt + 1;
        if (evt_if.evt_overrun) ocnt <= ocnt + 1;
        if (t4_watch && !(evt_if.evt_valid && evt_if.evt_id == 2'd0)) t4_bad <= t4_bad + 1;
        if (evt_if.evt_valid && evt_if.evt_ready && ev_n < 64) begin
            ev_id[ev_n]  <= int'(evt_if.evt_id);
            ev_cyc[ev_n] <= cyc;
`ifdef BUTTON_LONG_PRESS_EN
            ev_long[ev_n] <= int'(evt_if.evt_long);
`else
            ev_long[ev_n] <= 0;
`endif
            ev_n <= ev_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    initial begin
        int unsigned base, vbase, obase, lat;
        logic        seen;
        logic        lvl_hi;

        evt_if.evt_ready = 1'b0;
        wait_cycles(2);
        check_eq("rst_level",   32'(level), 0);
        check_eq("rst_valid",   32'(evt_if.evt_valid), 0);
        check_eq("rst_id",      32'(evt_if.evt_id), 0);
        check_eq("rst_overrun", 32'(evt_if.evt_overrun), 0);
        rst_n = 1'b1;
        wait_cycles(1);

        // 1: single press, level latency and one single-cycle event
        evt_if.evt_ready = 1'b1;
        base = ev_n; vbase = vcnt; lat = 0; seen = 1'b0;
        btn[2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!seen && level[2]) begin
                seen = 1'b1;
                lat  = i + 1;
            end
        end
        check_eq("t1_level_seen", 32'(seen), 1);
        check_eq("t1_latency_in_range", 32'(lat >= 12 && lat <= 18), 1);
        btn[2] = 1'b0;
        wait_cycles(30);
        check_eq("t1_event_count", ev_n - base, 1);
        check_eq("t1_event_id", ev_id[base], 2);
        check_eq("t1_valid_cycles", vcnt - vbase, 1);

        // 2: 6-cycle glitch is rejected
        base = ev_n; lvl_hi = 1'b0;
        btn[1] = 1'b1;
        wait_cycles(6);
        btn[1] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (level[1]) lvl_hi = 1'b1;
        end
        check_eq("t2_level_stays_low", 32'(lvl_hi), 0);
        check_eq("t2_no_event", ev_n - base, 0);

        // 3: simultaneous presses served in rotation, 2 cycles apart
        do_reset();
        evt_if.evt_ready = 1'b1;
        base = ev_n;
        btn = 4'b1011;
        wait_cycles(40);
        btn = 4'b0000;
        wait_cycles(30);
        check_eq("t3_event_count", ev_n - base, 3);
        check_eq("t3_id0", ev_id[base], 0);
        check_eq("t3_id1", ev_id[base+1], 1);
        check_eq("t3_id2", ev_id[base+2], 3);
        check_eq("t3_gap01", ev_cyc[base+1] - ev_cyc[base], 2);
        check_eq("t3_gap12", ev_cyc[base+2] - ev_cyc[base+1], 2);

        // 4: stalled consumer, repeat presses, overrun on the third
        do_reset();
        evt_if.evt_ready = 1'b0;
        base = ev_n; obase = ocnt;
        btn[0] = 1'b1;
        wait_cycles(24);
        check_eq("t4_offer_valid", 32'(evt_if.evt_valid), 1);
        check_eq("t4_offer_id", 32'(evt_if.evt_id), 0);
        t4_watch = 1'b1;
        btn[0] = 1'b0; wait_cycles(24);
        btn[0] = 1'b1; wait_cycles(24);
        btn[0] = 1'b0; wait_cycles(24);
        check_eq("t4_second_press_no_overrun", ocnt - obase, 0);
        btn[0] = 1'b1; wait_cycles(24);
        btn[0] = 1'b0; wait_cycles(24);
        check_eq("t4_third_press_overrun_cycles", ocnt - obase, 1);
        t4_watch = 1'b0;
        check_eq("t4_offer_stable", t4_bad, 0);
        evt_if.evt_ready = 1'b1;
        wait_cycles(20);
        check_eq("t4_event_count", ev_n - base, 2);
        check_eq("t4_ev0_id", ev_id[base], 0);
        check_eq("t4_ev1_id", ev_id[base+1], 0);

        // 5: reset during an offer drops the event
        do_reset();
        evt_if.evt_ready = 1'b0;
        seen = 1'b0;
        btn[2] = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (evt_if.evt_valid) seen = 1'b1;
        end
        check_eq("t5_offer_seen", 32'(seen), 1);
        base = ev_n;
        rst_n = 1'b0;
        btn = '0;
        #1;
        check_eq("t5_rst_valid", 32'(evt_if.evt_valid), 0);
        check_eq("t5_rst_id", 32'(evt_if.evt_id), 0);
        check_eq("t5_rst_level", 32'(level), 0);
        wait_cycles(3);
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        wait_cycles(40);
        check_eq("t5_no_event_after_reset", ev_n - base, 0);

`ifdef BUTTON_LONG_PRESS_EN
        // 6: long hold gives a short event then a long event
        do_reset();
        evt_if.evt_ready = 1'b1;
        base = ev_n;
        btn[3] = 1'b1;
        wait_cycles(80);
        btn[3] = 1'b0;
        wait_cycles(30);
        check_eq("t6_event_count", ev_n - base, 2);
        check_eq("t6_short_id", ev_id[base], 3);
        check_eq("t6_short_flag", ev_long[base], 0);
        check_eq("t6_long_id", ev_id[base+1], 3);
        check_eq("t6_long_flag", ev_long[base+1], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Controller for the front-panel push-buttons. Samples N raw button inputs and debounces each one on a shared slow sampling tick.
- Turns each debounced press (rising edge) into a pending request.
- A round-robin arbiter serialises pending requests onto a single valid/ready event channel, so one downstream consumer (toggle logic, mode FSM) can own all buttons.
- Replaces per-button debouncer instances plus per-button edge logic.

Parameters:
- N_BUTTONS, 4, number of button inputs (2..16).
- TICK_DIV, 50000, clk cycles per sampling tick (>=2).
- STABLE_TICKS, 4, consecutive ticks a new level must persist before it is accepted (>=1).
- IDW, 2, width of evt_id; must satisfy 2^IDW >= N_BUTTONS.
- LONG_TICKS, 250, ticks held before a press is classed long (only with the optional feature).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_in  input  N_BUTTONS  raw, asynchronous button levels, 1 = pressed.
- btn_level  output  N_BUTTONS  debounced level per button.
- evt_valid  output  1  event offered.
- evt_id  output  IDW  index of the button whose press is offered.
- evt_ready  input  1  consumer accepts the event.
- evt_overrun  output  1  one-cycle pulse: a press was lost.
- evt_long  output  1  long-press flag; present only with LONG_PRESS_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - btn_level=0, evt_valid=0, evt_id=0, evt_overrun=0, evt_long=0.
  - All pending flags = 0, tick counter = 0, stability counters = 0, rr_ptr = 0, arbiter state = IDLE.
  - Reset mid-offer drops the event with no handshake.
- Synchronisation: each btn_in passes through a 2-flop synchroniser; the debouncer sees only the synchronised value.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps; tick=1 for the single cycle where count==TICK_DIV-1.
- Debounce, per button, evaluated only on tick:
  - If sync != btn_level, stab_cnt increments.
  - When stab_cnt reaches STABLE_TICKS, btn_level takes sync and stab_cnt clears.
  - On any tick where sync == btn_level, stab_cnt clears.
  - Glitches shorter than STABLE_TICKS ticks never reach btn_level.
- Press detect: a btn_level 0->1 transition sets pending[i] on the following cycle. A 1->0 transition generates nothing.
- Arbiter FSM, 2 states:
  - IDLE: if any pending bit is set, grant the first set index found scanning upward from rr_ptr with wrap. Load evt_id, set evt_valid=1, clear pending[grant], go to OFFER. Otherwise stay in IDLE.
  - OFFER: evt_valid and evt_id are held stable until evt_ready=1. On handshake (valid & ready): evt_valid=0, rr_ptr=(evt_id+1) mod N_BUTTONS, go to IDLE.
  - Throughput is at most one event per 2 cycles.
  - evt_ready while evt_valid=0 is ignored.
- Boundary cases:
  - Press edge on button i while pending[i]=1 and i is not being granted that cycle: press is lost and evt_overrun pulses for 1 cycle.
  - Set and clear of pending[i] in the same cycle: set wins, no overrun.
  - A press on the button currently being offered sets pending normally.
  - All buttons pending: serviced in strict rotation; no button is starved.
  - rr_ptr wraps from N_BUTTONS-1 to 0.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- Defined:
  - Each button has a hold counter, incremented on tick while btn_level=1 and cleared when btn_level=0.
  - Hold counter reaching LONG_TICKS sets a long-pending flag; it fires at most once per press.
  - The arbiter treats long-pending as a second request class. Long requests take priority over short ones and use the same rr_ptr.
  - evt_long=1 accompanies a long event and is held with evt_valid.
  - The short event for that press is still produced on the rising edge, earlier.
- Undefined:
  - No hold counters.
  - The evt_long port is absent.

Test Plan:
Parameters for all tests: TICK_DIV=4, STABLE_TICKS=3, N_BUTTONS=4.
1. btn_in[2]=1 held 40 cycles, evt_ready=1 -> btn_level[2] rises 12..18 cycles after the edge; exactly one event with evt_id=2; evt_valid high for exactly 1 cycle.
2. btn_in[1] 1-pulse of 6 cycles -> btn_level stays 0; no event.
3. Buttons 0, 1, 3 pressed together, evt_ready=1 from the start -> events in order 0, 1, 3; consecutive evt_valid pulses 2 cycles apart.
4. Button 0 pressed, evt_ready=0 for 100 cycles -> evt_valid=1 with evt_id=0 held stable throughout. A second debounced press of button 0 during the stall sets pending and produces no overrun. A third press produces a 1-cycle evt_overrun pulse. Raising evt_ready then yields exactly two id=0 events.
5. reset driven 0 while evt_valid=1 -> outputs go to 0 immediately; no event is delivered after reset returns to 1.
6. BUTTON_LONG_PRESS_EN defined, LONG_TICKS=10, button 3 held 80 cycles -> short event id=3 with evt_long=0, then one event id=3 with evt_long=1.
